// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down modulo counter with prescaler.
//
// Counts 0..MAX_VAL inclusive, either wrapping or saturating at the bounds.
// A step happens once every PRESCALE enabled cycles. Synchronous clr/load
// override stepping (clr > load > step); rst is asynchronous and dominant.
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  inclusive upper bound, 1 .. 2^WIDTH-1
//   SATURATE 0: wrap at bounds, 1: hold at bounds
//   PRESCALE enabled cycles per count step (>= 1)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   en       count enable (advances the prescaler)
//   clr      synchronous clear of count, prescaler, tc and wrapped
//   load     synchronous load of min(load_val, MAX_VAL)
//   load_val value used by load
//   dir      1: count up, 0: count down
//   count    registered count
//   tc       one-cycle pulse following a boundary step
//   wrapped  sticky flag, set by any boundary step until clr/rst
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE = 1'b0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PscW-1:0]  psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic             at_bound;

  // Boundary in the current direction: MAX_VAL going up, 0 going down.
  assign at_bound = dir ? (count_q == MAX_VAL) : (count_q == '0);

  always_comb begin
    count_d   = count_q;
    psc_d     = psc_q;
    tc_d      = 1'b0;  // tc is a pulse; only a boundary step raises it
    wrapped_d = wrapped_q;
    if (clr) begin
      count_d   = '0;
      psc_d     = '0;
      wrapped_d = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      psc_d   = '0;
    end else if (en) begin
      if (psc_q == PscLast) begin
        psc_d = '0;
        if (at_bound) begin
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
          if (!SATURATE) begin
            count_d = dir ? '0 : MAX_VAL;
          end
        end else begin
          count_d = dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
      end else begin
        psc_d = psc_q + PscW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      psc_q     <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      psc_q     <= psc_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter. Four instances share one stimulus
// stream; a reference model pushes expected outputs per edge and a monitor
// pops and compares them on the falling edge.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1;
  logic [4:0] lv = '0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [4:0] cnt_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       wr_a, wr_b, wr_c, wr_d;

  always #5 clk = ~clk;

  // a: wrap mod 10; b: saturate mod 10; c: wrap, prescale 4; d: full 5-bit, prescale 3
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv[3:0]),
    .dir(dir), .count(cnt_a), .tc(tc_a), .wrapped(wr_a));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv[3:0]),
    .dir(dir), .count(cnt_b), .tc(tc_b), .wrapped(wr_b));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv[3:0]),
    .dir(dir), .count(cnt_c), .tc(tc_c), .wrapped(wr_c));
  mod_updown_counter #(.WIDTH(5), .MAX_VAL(5'd31), .SATURATE(1'b0), .PRESCALE(3)) u_d (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
    .dir(dir), .count(cnt_d), .tc(tc_d), .wrapped(wr_d));

  logic [3:0][4:0] act_cnt;
  logic [3:0]      act_tc, act_wr;
  assign act_cnt = {cnt_d, {1'b0, cnt_c}, {1'b0, cnt_b}, {1'b0, cnt_a}};
  assign act_tc  = {tc_d, tc_c, tc_b, tc_a};
  assign act_wr  = {wr_d, wr_c, wr_b, wr_a};

  // Model configuration and state, one slot per instance.
  int cfg_w[4]   = '{4, 4, 4, 5};
  int cfg_max[4] = '{9, 9, 9, 31};
  int cfg_sat[4] = '{0, 1, 0, 0};
  int cfg_pre[4] = '{1, 1, 4, 3};
  int m_cnt[4], m_ecnt[4], m_tc[4], m_wr[4];

  typedef struct packed {
    logic [4:0] cnt;
    logic       tc;
    logic       wr;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_edges  = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_ecnt[i] = 0; m_tc[i] = 0; m_wr[i] = 0;
    end
  endtask

  // Effect of one rising edge with the given inputs, in plain arithmetic.
  task automatic model_edge(input bit r, input bit e, input bit c, input bit l,
                            input int lval, input bit d);
    for (int i = 0; i < 4; i++) begin
      int m, v;
      bit step;
      m = cfg_max[i];
      m_tc[i] = 0;
      if (r || c) begin
        m_cnt[i] = 0; m_ecnt[i] = 0; m_wr[i] = 0;
      end else if (l) begin
        v = lval % (1 << cfg_w[i]);
        m_cnt[i] = (v > m) ? m : v;
        m_ecnt[i] = 0;
      end else if (e) begin
        m_ecnt[i] = m_ecnt[i] + 1;
        step = (m_ecnt[i] % cfg_pre[i]) == 0;
        if (step) begin
          m_ecnt[i] = 0;
          if ((d && m_cnt[i] == m) || (!d && m_cnt[i] == 0)) begin
            m_tc[i] = 1;
            m_wr[i] = 1;
          end
          if (d) m_cnt[i] = (cfg_sat[i] != 0 && m_cnt[i] == m) ? m : (m_cnt[i] + 1) % (m + 1);
          else   m_cnt[i] = (cfg_sat[i] != 0 && m_cnt[i] == 0) ? 0 : (m_cnt[i] + m) % (m + 1);
        end
      end
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{cnt: 5'(m_cnt[i]), tc: m_tc[i][0], wr: m_wr[i][0]});
    end
  endtask

  // Inputs are already driven; take one edge, update the model, queue results.
  task automatic edge_and_push();
    @(posedge clk);
    model_edge(rst, en, clr, load, int'(lv), dir);
    push_expected();
    #1;
  endtask

  task automatic tick(input bit e, input bit c, input bit l, input int lval, input bit d);
    en = e; clr = c; load = l; lv = 5'(lval); dir = d;
    edge_and_push();
  endtask

  task automatic check_reset_state(input string name);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (act_cnt[i] == 5'd0 && act_tc[i] == 1'b0 && act_wr[i] == 1'b0) n_pass++;
      else $display("FAIL %s inst%0d: got count=%0d tc=%0d wrapped=%0d, expected 0/0/0",
                    name, i, act_cnt[i], act_tc[i], act_wr[i]);
    end
  endtask

  // Raise rst between edges and verify outputs clear before the next edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state(name);
    model_reset();
    edge_and_push();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() >= 4) begin
      n_edges++;
      for (int i = 0; i < 4; i++) begin
        exp_t x;
        x = exp_q.pop_front();
        n_checks++;
        if (act_cnt[i] == x.cnt && act_tc[i] == x.tc && act_wr[i] == x.wr) n_pass++;
        else $display("FAIL edge%0d inst%0d: got count=%0d tc=%0d wrapped=%0d, expected count=%0d tc=%0d wrapped=%0d",
                      n_edges, i, act_cnt[i], act_tc[i], act_wr[i], x.cnt, x.tc, x.wr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit rdir;
    model_reset();
    #2;
    check_reset_state("reset_state");
    edge_and_push();
    rst = 1'b0;

    // Wrap up for 12 enabled cycles, then 4 more (prescaled instance reaches 4).
    for (int k = 0; k < 16; k++) tick(1, 0, 0, 0, 1);

    // Clear, load 2, count down into the lower bound.
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 2, 0);
    for (int k = 0; k < 5; k++) tick(1, 0, 0, 0, 0);

    // Prescaler with a 3-cycle enable gap in the middle.
    tick(0, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) tick(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) tick(1, 0, 0, 0, 1);

    // Load clamp, then clr and load together.
    tick(0, 0, 1, 15, 1);
    tick(1, 0, 0, 0, 1);
    tick(0, 1, 1, 5, 1);
    tick(1, 0, 0, 0, 1);

    // Load during a prescaler terminal cycle: load wins, no step.
    tick(0, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 1, 9, 1);
    tick(1, 0, 0, 0, 1);

    // Reach count=7 with wrapped set, then asynchronous reset mid-cycle.
    tick(0, 0, 1, 9, 1);
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 1, 7, 1);
    async_reset("async_reset");
    for (int k = 0; k < 4; k++) tick(1, 0, 0, 0, 1);

    // Direction flip: 5 -> 6 -> 5 -> 4.
    tick(0, 0, 1, 5, 1);
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);

    // Randomized run; direction held in stretches so bounds are reached.
    rdir = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) rdir = ~rdir;
      if ($urandom_range(0, 399) == 0) async_reset("async_reset_rand");
      else tick($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 23) == 0, int'($urandom_range(0, 31)), rdir);
    end

    en = 1'b0; clr = 1'b0; load = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised successor to the free-running 32-bit counter with asynchronous reset. Adds programmable width, a modulus, up/down direction, synchronous clear and load, an enable prescaler, and wrap-or-saturate behaviour. It reports boundary events through a one-cycle terminal-count pulse and a sticky wrap flag. Used as the general timebase, event counter and divider primitive across the design.

## Interface
- WIDTH, 32: counter width in bits (≥2).
- MAX_VAL, 2^WIDTH−1: upper count bound, inclusive. Must satisfy 1 ≤ MAX_VAL ≤ 2^WIDTH−1.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.
- PRESCALE, 1: number of enabled cycles per count step (≥1).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; feeds the prescaler.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value for load.
- dir  in  1  1 = count up, 0 = count down.
- count  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse.
- wrapped  out  1  sticky boundary-event flag.

## Operation
- Reset: while rst is high, count=0, tc=0, wrapped=0 and prescaler=0, independent of clk. Reset takes effect immediately, including mid-count.
- Priority on each rising edge: rst > clr > load > step.
- clr:
  - count←0, prescaler←0, wrapped←0, tc←0.
- load:
  - count←min(load_val, MAX_VAL); prescaler←0; tc←0; wrapped unchanged.
- Prescaler:
  - Internal counter of width max(1, clog2(PRESCALE)).
  - When en=1 and neither clr nor load is active: if prescaler==PRESCALE−1, a step occurs and prescaler←0; otherwise prescaler increments.
  - en=0 freezes the prescaler.
  - PRESCALE=1 gives a step on every enabled cycle.
- Step, up (dir=1):
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: count←0 if SATURATE=0, held if SATURATE=1.
- Step, down (dir=0):
  - count>0: count−1.
  - count==0: count←MAX_VAL if SATURATE=0, held if SATURATE=1.
- Boundary event: a step taken while count is already at the bound in the current direction (MAX_VAL going up, 0 going down).
  - Sets tc=1 for exactly the next cycle.
  - Sets wrapped=1, which stays set until clr or rst.
- Arithmetic:
  - Increment and decrement are WIDTH-bit unsigned operations with no carry out.
  - count never exceeds MAX_VAL, even if a load requests a larger value.
- Direction changes take effect on the next step. No state is kept per direction.

## Timing
- All outputs are registered. count changes on the same rising edge at which a step, load or clr is sampled, so the latency is 1 cycle.
- tc is high during the cycle that follows the edge at which the boundary step occurred. It is never high for two consecutive cycles unless boundary steps happen on consecutive edges, e.g. SATURATE=1, PRESCALE=1, en held high.
- Simultaneous clr and load: clr wins and load_val is ignored.
- Simultaneous load and a prescaler terminal cycle: load wins, no step occurs, and tc stays 0.
- rst deasserted between edges: counting resumes from 0 on the first edge at which en=1 and prescaler conditions are met.

## Test plan
- Wrap up: WIDTH=4, MAX_VAL=9, PRESCALE=1, dir=1, en held high for 12 cycles -> count goes 0..9, 0, 1. tc is high exactly one cycle, the cycle count reads 0 after 9. wrapped=1 from then on.
- Down and saturate: SATURATE=1, MAX_VAL=9, load 2, dir=0, en held high -> count goes 2, 1, 0, 0, 0. tc is high the cycle after each step taken at 0. wrapped=1.
- Prescaler: PRESCALE=4, en high for 16 cycles from reset -> count reaches 4 and steps occur every 4th enabled cycle. Holding en low for 3 cycles in the middle delays the next step by 3 cycles.
- Load clamp and priority: MAX_VAL=9, load_val=15 -> count=9. Asserting clr and load (load_val=5) together -> count=0 and wrapped=0.
- Asynchronous reset mid-count: assert rst between edges while count=7 and wrapped=1 -> count=0, tc=0 and wrapped=0 before the next clk edge. After release, counting restarts from 0.
- Direction flip: count=5, step up, then dir=0 for two steps -> count goes 6, 5, 4 with tc=0 throughout.
